// File: rtl/byte_serial_wide_adder_pkg.sv
// Shared types and constants for the byte-serial wide adder.
package byte_serial_wide_adder_pkg;

    localparam int unsigned BYTE_W = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2,
        DONE  = 2'd3
    } state_e;

endpackage

// File: rtl/byte_serial_wide_adder_ks8.sv
// Registered 8-bit Kogge-Stone adder: sum and carry-out are captured on the clock edge.
module byte_serial_wide_adder_ks8
    import byte_serial_wide_adder_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [BYTE_W-1:0] a_i,
    input  logic [BYTE_W-1:0] b_i,
    input  logic              ci_i,
    output logic [BYTE_W-1:0] sum_o,
    output logic              co_o
);

    localparam int unsigned LVLS = 3;

    logic [BYTE_W-1:0] g [LVLS+1];
    logic [BYTE_W-1:0] p [LVLS+1];
    logic [BYTE_W:0]   c;
    logic [BYTE_W-1:0] sum_d;
    logic [BYTE_W-1:0] sum_q;
    logic              co_q;

    // Parallel-prefix group generate/propagate; carry-in folded in at the end.
    always_comb begin
        g = '{default: '0};
        p = '{default: '0};
        c = '0;
        g[0] = a_i & b_i;
        p[0] = a_i ^ b_i;
        for (int unsigned l = 0; l < LVLS; l++) begin
            for (int unsigned i = 0; i < BYTE_W; i++) begin
                if (i >= (32'd1 << l)) begin
                    g[l+1][i] = g[l][i] | (p[l][i] & g[l][i-(32'd1 << l)]);
                    p[l+1][i] = p[l][i] & p[l][i-(32'd1 << l)];
                end else begin
                    g[l+1][i] = g[l][i];
                    p[l+1][i] = p[l][i];
                end
            end
        end
        c[0] = ci_i;
        for (int unsigned i = 0; i < BYTE_W; i++) begin
            c[i+1] = g[LVLS][i] | (p[LVLS][i] & ci_i);
        end
        sum_d = p[0] ^ c[BYTE_W-1:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sum_q <= '0;
            co_q  <= 1'b0;
        end else begin
            sum_q <= sum_d;
            co_q  <= c[BYTE_W];
        end
    end

    assign sum_o = sum_q;
    assign co_o  = co_q;

endmodule

// File: rtl/byte_serial_wide_adder.sv
// Multi-byte add/subtract sequencer: streams operands LSB-first through the registered
// 8-bit adder, chains carries byte to byte and reassembles the wide result.
module byte_serial_wide_adder
    import byte_serial_wide_adder_pkg::*;
#(
    parameter int unsigned NBYTES = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [BYTE_W*NBYTES-1:0] in_a,
    input  logic [BYTE_W*NBYTES-1:0] in_b,
    input  logic                   in_ci,
    input  logic                   in_sub,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [BYTE_W*NBYTES-1:0] out_sum,
    output logic                   out_co,
    output logic                   out_ovf
);

    localparam int unsigned W    = BYTE_W * NBYTES;
    localparam int unsigned IDXW = $clog2(NBYTES);

    state_e            state_q;
    logic [IDXW-1:0]   idx_q;
    logic [W-1:0]      a_q;
    logic [W-1:0]      b_q;
    logic              ci_q;
    logic              sub_q;
    logic [W-1:0]      sum_q;
    logic              co_q;
    logic              ovf_q;
    logic              valid_q;

    logic [W-1:0]      a_sh;
    logic [W-1:0]      b_sh;
    logic [BYTE_W-1:0] ks_a;
    logic [BYTE_W-1:0] ks_b;
    logic              ks_ci;
    logic [BYTE_W-1:0] ks_sum;
    logic              ks_co;

    // Byte select for the adder; inputs parked at zero outside RUN.
    always_comb begin
        a_sh  = '0;
        b_sh  = '0;
        ks_a  = '0;
        ks_b  = '0;
        ks_ci = 1'b0;
        if (state_q == RUN) begin
            a_sh  = a_q >> {idx_q, 3'b000};
            b_sh  = b_q >> {idx_q, 3'b000};
            ks_a  = a_sh[BYTE_W-1:0];
            ks_b  = b_sh[BYTE_W-1:0];
            ks_ci = (idx_q == '0) ? ci_q : ks_co;
        end
    end

    byte_serial_wide_adder_ks8 u_ks8 (
        .clk   (clk),
        .rst   (rst),
        .a_i   (ks_a),
        .b_i   (ks_b),
        .ci_i  (ks_ci),
        .sum_o (ks_sum),
        .co_o  (ks_co)
    );

    // Sequencer; the adder output lags its inputs by one edge, so byte k lands at E(k+2).
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            ci_q    <= 1'b0;
            sub_q   <= 1'b0;
            sum_q   <= '0;
            co_q    <= 1'b0;
            ovf_q   <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        a_q     <= in_a;
                        b_q     <= in_sub ? ~in_b : in_b;
                        ci_q    <= in_sub ^ in_ci;
                        sub_q   <= in_sub;
                        idx_q   <= '0;
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    for (int unsigned j = 1; j < NBYTES; j++) begin
                        if (idx_q == IDXW'(j)) begin
                            sum_q[(j-1)*BYTE_W +: BYTE_W] <= ks_sum;
                        end
                    end
                    idx_q <= idx_q + 1'b1;
                    if (idx_q == IDXW'(NBYTES-1)) begin
                        state_q <= FLUSH;
                    end
                end
                FLUSH: begin
                    sum_q[W-1 -: BYTE_W] <= ks_sum;
                    co_q    <= ks_co ^ sub_q;
                    ovf_q   <= (a_q[W-1] == b_q[W-1]) && (ks_sum[BYTE_W-1] != a_q[W-1]);
                    valid_q <= 1'b1;
                    idx_q   <= '0;
                    state_q <= DONE;
                end
                DONE: begin
                    if (out_ready) begin
                        valid_q <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = valid_q;
    assign out_sum   = sum_q;
    assign out_co    = co_q;
    assign out_ovf   = ovf_q;

endmodule

// File: tb/tb_byte_serial_wide_adder.sv
// Directed bench for byte_serial_wide_adder with an arithmetic reference model and scoreboard.
module tb_byte_serial_wide_adder;

    localparam int unsigned NB = 4;
    localparam int unsigned LAT = NB + 1;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_a;
    logic [31:0] in_b;
    logic        in_ci;
    logic        in_sub;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_sum;
    logic        out_co;
    logic        out_ovf;

    int n_vec = 0;
    int n_bad = 0;
    int cyc   = 0;

    typedef struct {
        logic [31:0] sum;
        logic        co;
        logic        ovf;
        int          acc;
    } exp_t;

    exp_t q[$];
    bit   first_seen = 1'b0;

    byte_serial_wide_adder #(.NBYTES(NB)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_ci     (in_ci),
        .in_sub    (in_sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_co    (out_co),
        .out_ovf   (out_ovf)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Plain 33-bit arithmetic reference: sum mod 2^32, carry/borrow, signed overflow.
    function automatic exp_t model(input logic [31:0] a, input logic [31:0] b,
                                   input logic ci, input logic sub);
        exp_t        r;
        logic [32:0] full;
        if (!sub) full = {1'b0, a} + {1'b0, b} + 33'(ci);
        else      full = {1'b0, a} - {1'b0, b} - 33'(ci);
        r.sum = full[31:0];
        r.co  = full[32];
        if (!sub) r.ovf = (a[31] == b[31]) && (r.sum[31] != a[31]);
        else      r.ovf = (a[31] != b[31]) && (r.sum[31] != a[31]);
        r.acc = 0;
        return r;
    endfunction

    // Scoreboard compare: inputs change #1 after posedge, so negedge sees settled values
    // and predicts what the coming edge will do.
    always @(negedge clk) begin
        if (rst) begin
            q.delete();
            first_seen = 1'b0;
        end else begin
            chk("in_ready_vs_busy", in_ready, (q.size() == 0));
            if (q.size() == 0) begin
                chk("idle_out_valid", out_valid, 1'b0);
            end else if (out_valid) begin
                chk("out_sum", out_sum, q[0].sum);
                chk("out_co", out_co, q[0].co);
                chk("out_ovf", out_ovf, q[0].ovf);
                if (!first_seen) begin
                    chk("latency", cyc - q[0].acc, LAT);
                    first_seen = 1'b1;
                end
            end
            if (out_valid && out_ready && q.size() != 0) begin
                void'(q.pop_front());
                first_seen = 1'b0;
            end
            if (in_valid && in_ready) begin
                exp_t e;
                e     = model(in_a, in_b, in_ci, in_sub);
                e.acc = cyc + 1;
                q.push_back(e);
            end
        end
    end

    task automatic issue(input logic [31:0] a, input logic [31:0] b,
                         input logic ci, input logic sub);
        bit ok;
        ok = 1'b0;
        @(posedge clk);
        #1;
        in_a = a; in_b = b; in_ci = ci; in_sub = sub; in_valid = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk("issue_timeout", 32'(ok), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_valid(input string nm);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (out_valid) begin
                ok = 1'b1;
                break;
            end
        end
        chk(nm, 32'(ok), 32'd1);
    endtask

    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic ci,
                          input logic sub, input logic [31:0] es, input logic eco,
                          input logic eov);
        exp_t m;
        m = model(a, b, ci, sub);
        chk("model_sum", m.sum, es);
        chk("model_co", m.co, eco);
        chk("model_ovf", m.ovf, eov);
        issue(a, b, ci, sub);
        wait_valid("result_timeout");
        chk("lit_sum", out_sum, es);
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_ci = 1'b0; in_sub = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_out_sum", out_sum, 32'h0);
        chk("rst_out_co", out_co, 1'b0);
        chk("rst_out_ovf", out_ovf, 1'b0);
        chk("rst_in_ready", in_ready, 1'b1);

        run_op(32'h000000FF, 32'h00000001, 1'b0, 1'b0, 32'h00000100, 1'b0, 1'b0);
        run_op(32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b0);
        run_op(32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h80000000, 1'b0, 1'b1);
        run_op(32'h12345678, 32'h11111111, 1'b1, 1'b0, 32'h2345678A, 1'b0, 1'b0);
        run_op(32'h00000000, 32'h00000001, 1'b0, 1'b1, 32'hFFFFFFFF, 1'b1, 1'b0);
        run_op(32'h80000000, 32'h00000001, 1'b0, 1'b1, 32'h7FFFFFFF, 1'b0, 1'b1);

        // Backpressure with a second operation queued on in_valid.
        out_ready = 1'b0;
        issue(32'hA5A5A5A5, 32'h0F0F0F0F, 1'b0, 1'b0);
        in_a = 32'h01020304; in_b = 32'h00010203; in_ci = 1'b0; in_sub = 1'b1;
        in_valid = 1'b1;
        wait_valid("bp_timeout");
        for (int i = 0; i < 3; i++) begin
            chk("bp_valid_held", out_valid, 1'b1);
            chk("bp_in_ready", in_ready, 1'b0);
            chk("bp_sum_lit", out_sum, 32'hB4B4B4B4);
            @(negedge clk);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("bp_in_ready_after", in_ready, 1'b1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        wait_valid("queued_timeout");
        chk("queued_sum_lit", out_sum, 32'h01010101);
        @(posedge clk);
        #1;

        // Reset while the adder is on byte 2.
        issue(32'h11111111, 32'h22222222, 1'b0, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_out_valid", out_valid, 1'b0);
        chk("midrst_out_sum", out_sum, 32'h0);
        chk("midrst_in_ready", in_ready, 1'b1);
        run_op(32'h00000001, 32'h00000001, 1'b0, 1'b0, 32'h00000002, 1'b0, 1'b0);

        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
